// File: rtl/write_master_burst_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | write_master_burst_fifo : FIFO-buffered Avalon-MM write master with      |
// | job control and start-address rebasing.            Revision 1.0          |
// +--------------------------------------------------------------------------+
module write_master_burst_fifo #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int BE_W       = DATA_W / 8
) (
  input  logic                        iClk,
  input  logic                        iReset,
  input  logic                        iStart,
  input  logic [ADDR_W-1:0]           iStart_write_address,
  output logic                        oDone,
  output logic                        oBusy,
  input  logic                        iWait_request,
  output logic                        oWrite,
  output logic [ADDR_W-1:0]           oWrite_address,
  output logic [DATA_W-1:0]           oWrite_data,
  output logic [BE_W-1:0]             oByte_enable,
  input  logic                        iWM_write_request,
  input  logic [ADDR_W-1:0]           iWM_write_address,
  input  logic [DATA_W-1:0]           iWM_write_data,
  input  logic [BE_W-1:0]             iWM_byte_enable,
  input  logic                        iFinish,
  output logic                        oWait_request,
  output logic [$clog2(FIFO_DEPTH):0] oFifo_level,
  output logic [31:0]                 oWrite_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + BE_W + DATA_W;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [BE_W-1:0]   out_be_q, out_be_d;

  logic             wait_req;
  logic             start_acc;
  logic             push;
  logic             bus_done;
  logic             load;
  logic [ENT_W-1:0] push_entry;
  logic [ENT_W-1:0] head_entry;

  // The stall is decoded from the registered level, so a pop in the same
  // cycle never opens room for a push at full.
  assign wait_req   = (state_q != S_RUN) || (level_q == FULL_LVL);
  assign start_acc  = iStart && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign push       = iWM_write_request && !wait_req;
  assign bus_done   = out_valid_q && !iWait_request;
  assign load       = (level_q != '0) && (!out_valid_q || bus_done);
  assign push_entry = {base_q + iWM_write_address, iWM_byte_enable, iWM_write_data};
  assign head_entry = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iStart) state_d = S_RUN;
      S_RUN:   if (iFinish) state_d = S_DRAIN;
      S_DRAIN: if ((level_q == '0) && (!out_valid_q || bus_done)) state_d = S_DONE;
      S_DONE:  if (iStart) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    base_d      = base_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_be_d    = out_be_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (load) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, load})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Bus fields only change on a load, which keeps them stable through a stall.
    if (load) begin
      out_valid_d                          = 1'b1;
      {out_addr_d, out_be_d, out_data_d}   = head_entry;
    end else if (bus_done) begin
      out_valid_d = 1'b0;
    end

    if (start_acc) begin
      base_d  = iStart_write_address;
      count_d = '0;
    end else if (bus_done) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      base_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      base_q      <= base_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_be_q    <= out_be_d;
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge iClk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign oDone          = (state_q == S_DONE);
  assign oBusy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign oWait_request  = wait_req;
  assign oFifo_level    = level_q;
  assign oWrite_count   = count_q;
  assign oWrite         = out_valid_q;
  assign oWrite_address = out_addr_q;
  assign oWrite_data    = out_data_q;
  assign oByte_enable   = out_be_q;

endmodule
`default_nettype wire

// File: tb/tb_write_master_burst_fifo.sv
`default_nettype none
// Testbench for write_master_burst_fifo: directed and random jobs compared
// cycle by cycle against a queue-based reference model.
module tb_write_master_burst_fifo;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 16;
  localparam int BEW   = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } ent_t;

  logic            clk = 1'b0;
  logic            iReset, iStart, iWait_request, iWM_write_request, iFinish;
  logic [AW-1:0]   iStart_write_address, iWM_write_address;
  logic [DW-1:0]   iWM_write_data;
  logic [BEW-1:0]  iWM_byte_enable;
  logic            oDone, oBusy, oWrite, oWait_request;
  logic [AW-1:0]   oWrite_address;
  logic [DW-1:0]   oWrite_data;
  logic [BEW-1:0]  oByte_enable;
  logic [4:0]      oFifo_level;
  logic [31:0]     oWrite_count;

  always #5 clk = ~clk;

  write_master_burst_fifo #(
    .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .iClk(clk), .iReset(iReset), .iStart(iStart),
    .iStart_write_address(iStart_write_address),
    .oDone(oDone), .oBusy(oBusy), .iWait_request(iWait_request),
    .oWrite(oWrite), .oWrite_address(oWrite_address),
    .oWrite_data(oWrite_data), .oByte_enable(oByte_enable),
    .iWM_write_request(iWM_write_request), .iWM_write_address(iWM_write_address),
    .iWM_write_data(iWM_write_data), .iWM_byte_enable(iWM_byte_enable),
    .iFinish(iFinish), .oWait_request(oWait_request),
    .oFifo_level(oFifo_level), .oWrite_count(oWrite_count)
  );

  // Reference model: queued entries, the entry on the bus, job state.
  ent_t        mq[$];
  ent_t        m_out;
  bit          m_ov;
  int          m_st;
  logic [31:0] m_base;
  logic [31:0] m_cnt;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out  = '0;
    m_ov   = 1'b0;
    m_st   = M_IDLE;
    m_base = '0;
    m_cnt  = '0;
  endtask

  // Compare this cycle's outputs, advance the model with this cycle's inputs,
  // then move to 1 time unit past the next rising edge.
  task automatic cycle();
    bit   wreq, push, comp, load;
    int   nst;
    ent_t e;
    wreq = (m_st != M_RUN) || (mq.size() == DEPTH);
    chk("wait_request", oWait_request, wreq);
    chk("fifo_level", oFifo_level, mq.size());
    chk("write", oWrite, m_ov);
    if (m_ov) begin
      chk("address", oWrite_address, m_out.a);
      chk("data", oWrite_data, m_out.d);
      chk("byte_enable", oByte_enable, m_out.be);
    end
    chk("write_count", oWrite_count, m_cnt);
    chk("done", oDone, m_st == M_DONE);
    chk("busy", oBusy, (m_st == M_RUN) || (m_st == M_DRAIN));

    push = iWM_write_request && !wreq;
    comp = m_ov && !iWait_request;
    load = (mq.size() != 0) && (!m_ov || comp);

    nst = m_st;
    if ((m_st == M_IDLE || m_st == M_DONE) && iStart) nst = M_RUN;
    else if (m_st == M_RUN && iFinish) nst = M_DRAIN;
    else if (m_st == M_DRAIN && mq.size() == 0 && (!m_ov || comp)) nst = M_DONE;

    if (iReset) begin
      model_reset();
    end else begin
      if (comp) m_cnt = m_cnt + 32'd1;
      if (load) begin
        m_out = mq.pop_front();
        m_ov  = 1'b1;
      end else if (comp) begin
        m_ov = 1'b0;
      end
      if (push) begin
        e.a  = m_base + iWM_write_address;
        e.be = iWM_byte_enable;
        e.d  = iWM_write_data;
        mq.push_back(e);
      end
      if ((m_st == M_IDLE || m_st == M_DONE) && iStart) begin
        m_base = iStart_write_address;
        m_cnt  = '0;
      end
      m_st = nst;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] base);
    iStart = 1'b1;
    iStart_write_address = base;
    cycle();
    iStart = 1'b0;
  endtask

  task automatic set_push(input bit req, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    iWM_write_request = req;
    iWM_write_address = a;
    iWM_write_data    = d;
    iWM_byte_enable   = be;
  endtask

  task automatic finish_and_wait(input string tag);
    iWM_write_request = 1'b0;
    iFinish = 1'b1;
    cycle();
    iFinish = 1'b0;
    iWait_request = 1'b0;
    for (int k = 0; k < 100 && !oDone; k++) cycle();
    chk(tag, oDone, 1'b1);
  endtask

  initial begin
    iReset = 1'b1; iStart = 1'b0; iStart_write_address = '0;
    iWait_request = 1'b0; iFinish = 1'b0;
    set_push(1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    iReset = 1'b0;
    chk("rst_write", oWrite, 1'b0);
    chk("rst_addr", oWrite_address, 32'h0);
    chk("rst_data", oWrite_data, 32'h0);
    chk("rst_be", oByte_enable, 4'h0);
    chk("rst_waitreq", oWait_request, 1'b1);
    chk("rst_done", oDone, 1'b0);
    chk("rst_busy", oBusy, 1'b0);
    cycle();

    // Basic job with latency check
    start_job(32'h1000_0000);
    set_push(1'b1, 32'h0, 32'hA0, 4'hF);
    cycle();
    chk("lat_n1", oWrite, 1'b0);
    set_push(1'b1, 32'h4, 32'hA1, 4'hF);
    cycle();
    chk("lat_n2", oWrite, 1'b1);
    chk("basic_first_addr", oWrite_address, 32'h1000_0000);
    set_push(1'b1, 32'h8, 32'hA2, 4'hF);
    cycle();
    set_push(1'b1, 32'hC, 32'hA3, 4'hF);
    cycle();
    finish_and_wait("basic_done");
    chk("basic_count", oWrite_count, 32'd4);

    // Backpressure: 5-cycle stall mid-stream
    start_job(32'h2000_0000);
    for (int i = 0; i < 8; i++) begin
      set_push(1'b1, 32'(i * 4), $urandom, 4'($urandom));
      iWait_request = (i >= 2) && (i < 7);
      cycle();
    end
    iWait_request = 1'b0;
    finish_and_wait("bp_done");
    chk("bp_count", oWrite_count, 32'd8);

    // Full FIFO: 20 push attempts under a held stall
    start_job(32'h0000_4000);
    iWait_request = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_push(1'b1, 32'(i * 4), $urandom, 4'hF);
      cycle();
    end
    chk("full_waitreq", oWait_request, 1'b1);
    chk("full_level", oFifo_level, 5'd16);
    finish_and_wait("full_done");
    chk("full_count", oWrite_count, 32'd17);

    // Address wrap and byte enables
    start_job(32'hFFFF_FFF8);
    set_push(1'b1, 32'h10, $urandom, 4'b0101);
    cycle();
    set_push(1'b0, '0, '0, '0);
    for (int k = 0; k < 20 && !oWrite; k++) cycle();
    chk("wrap_write", oWrite, 1'b1);
    chk("wrap_addr", oWrite_address, 32'h0000_0008);
    chk("wrap_be", oByte_enable, 4'b0101);
    finish_and_wait("wrap_done");

    // Zero-write job: done exactly two cycles after iFinish
    start_job(32'h5000_0000);
    iFinish = 1'b1;
    cycle();
    iFinish = 1'b0;
    chk("zero_done_n1", oDone, 1'b0);
    cycle();
    chk("zero_done_n2", oDone, 1'b1);

    // iStart while running is ignored
    start_job(32'h3000_0000);
    iStart = 1'b1;
    iStart_write_address = 32'h4000_0000;
    set_push(1'b1, 32'h20, 32'h1234_5678, 4'hF);
    cycle();
    iStart = 1'b0;
    set_push(1'b0, '0, '0, '0);
    for (int k = 0; k < 20 && !oWrite; k++) cycle();
    chk("start_run_addr", oWrite_address, 32'h3000_0020);
    finish_and_wait("start_run_done");

    // Random traffic
    start_job($urandom);
    for (int i = 0; i < 80; i++) begin
      set_push(($urandom % 3) != 0, $urandom, $urandom, 4'($urandom));
      iWait_request = ($urandom % 4) == 0;
      cycle();
    end
    finish_and_wait("rand_done");

    // Reset with 3 writes pending
    start_job(32'h6000_0000);
    iWait_request = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, 32'(i * 4), $urandom, 4'hF);
      cycle();
    end
    set_push(1'b0, '0, '0, '0);
    iReset = 1'b1;
    cycle();
    iReset = 1'b0;
    chk("rst2_write", oWrite, 1'b0);
    chk("rst2_level", oFifo_level, 5'd0);
    chk("rst2_waitreq", oWait_request, 1'b1);
    chk("rst2_count", oWrite_count, 32'd0);
    chk("rst2_addr", oWrite_address, 32'h0);
    chk("rst2_busy", oBusy, 1'b0);
    iWait_request = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rst2_nowrite", oWrite, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/write_master_burst_fifo.md
# write_master_burst_fifo

Parametrised Avalon-MM write master that sits between a pixel/feature-producing client (WRITE_MASTER side) and the system bus. Client writes carry a relative address, data and byte enables. They are buffered in an internal FIFO, rebased onto a start address latched at job start, and issued on the bus with full wait-request handling. A job state machine reports completion only once every accepted write has actually been taken by the bus.

## Interface
Parameters:
- DATA_W, 32, data width in bits; multiple of 8
- ADDR_W, 32, bus and offset address width
- FIFO_DEPTH, 16, FIFO entries; power of two, at least 4
- BE_W, DATA_W/8, byte-enable width (derived; do not override)

Ports:
- iClk  in  1  single clock; all logic rising-edge
- iReset  in  1  synchronous, active-high reset
- iStart  in  1  one-cycle job start pulse
- iStart_write_address  in  ADDR_W  base address, latched on accepted iStart
- oDone  out  1  job complete; held until next accepted iStart
- oBusy  out  1  high in RUN and DRAIN
- iWait_request  in  1  Avalon waitrequest
- oWrite  out  1  Avalon write
- oWrite_address  out  ADDR_W  Avalon address
- oWrite_data  out  DATA_W  Avalon writedata
- oByte_enable  out  BE_W  Avalon byteenable
- iWM_write_request  in  1  client write strobe
- iWM_write_address  in  ADDR_W  client offset address
- iWM_write_data  in  DATA_W  client data
- iWM_byte_enable  in  BE_W  client byte enables
- iFinish  in  1  client has issued its last write
- oWait_request  out  1  client stall; push is refused while high
- oFifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- oWrite_count  out  32  bus writes completed since the last accepted iStart

## Operation
- States: IDLE (reset state), RUN, DRAIN, DONE.
- IDLE/DONE with iStart: go to RUN. In the same edge, latch the base, clear oDone, and clear oWrite_count. iStart in RUN/DRAIN is ignored.
- Push (client side):
  - A push is accepted when iWM_write_request=1 and oWait_request=0.
  - The entry stored is {base + iWM_write_address, iWM_byte_enable, iWM_write_data}.
  - The address sum is modulo 2^ADDR_W; wrap is silent.
- oWait_request = 1 when the state is not RUN, or when oFifo_level == FIFO_DEPTH. Requests made while oWait_request=1 are not stored.
- RUN with iFinish: go to DRAIN. A push in that same cycle is still accepted when oWait_request=0.
- Output stage:
  - One output register holds the head entry and drives oWrite, address, data and byte enables.
  - It loads from the FIFO when it is empty, or when its current transfer completes (oWrite=1, iWait_request=0) and the FIFO is non-empty.
  - When oWrite=1 and iWait_request=1, all bus outputs hold stable.
  - On completion with the FIFO empty, oWrite falls.
- oWrite_count increments by 1 on each completed transfer and wraps at 2^32.
- DRAIN to DONE: FIFO empty, output register empty, no completion pending.
- DONE: oDone=1 and oBusy=0. Bus outputs stay idle.
- Simultaneous push and pop: the level is unchanged. A push at full is refused even if a pop happens in the same cycle, because oWait_request is decoded from the level.

## Timing
- Reset values:
  - state IDLE
  - oDone=0, oBusy=0, oWrite=0
  - oWrite_address, oWrite_data, oByte_enable all 0
  - oWait_request=1, oFifo_level=0, oWrite_count=0
  - base=0
- Reset in any state, including mid-transfer: the FIFO and output register are flushed at that edge and the pending write is abandoned. oWrite is low in the following cycle.
- Latency: push accepted in cycle N, with FIFO and output register empty, gives oWrite=1 in cycle N+2.
- Throughput: 1 write per cycle while iWait_request=0 and the FIFO is non-empty.
- Total capacity is FIFO_DEPTH+1 entries (FIFO plus output register).
- oDone rises one cycle after the last completion, provided iFinish has already been seen.
- Job with zero writes: iFinish, then DONE two cycles later (RUN to DRAIN to DONE).
- oFifo_level and oWrite_count are registered and reflect the previous edge.

## Test plan
- Basic job: base 0x1000_0000, 4 pushes at offsets 0,4,8,C with data 0xA0..0xA3 and iWait_request=0. Required: bus addresses 0x1000_0000..0x1000_000C in order, oWrite first high 2 cycles after the first push, oWrite_count=4, oDone after iFinish.
- Backpressure: iWait_request held high for 5 cycles mid-stream. Required: address, data and byte enables unchanged across the stall, no write lost or duplicated, order preserved.
- Full FIFO: with FIFO_DEPTH=16 and iWait_request=1, push 20 times. Required: oWait_request=1 once the level reaches 16 with one entry in the output register. Pushes refused while oWait_request=1 are not stored. Release gives exactly 17 writes.
- Wrap and byte enables: base 0xFFFF_FFF8, offset 0x10, be 4'b0101. Required: bus address 0x0000_0008 and oByte_enable 4'b0101.
- Control corner cases:
  - iFinish with no pushes: oDone after 2 cycles.
  - iStart during RUN: ignored, base unchanged.
  - iReset asserted with 3 entries pending: all outputs return to reset values next cycle, and no further writes are issued.
